// File: rtl/tcam_pkg.sv
// Shared constants for the ternary CAM.
//   DEF_IDX_W / DEF_DATA_W : default index and key widths
//   MISS_INDEX_ALL         : all-ones miss index; truncate to the index width in use
//   cnt_width()            : width of an occupancy counter for a given index width
package tcam_pkg;

    localparam int unsigned DEF_IDX_W  = 5;
    localparam int unsigned DEF_DATA_W = 32;

    localparam logic [31:0] MISS_INDEX_ALL = 32'hFFFF_FFFF;

    // One extra bit so a completely full array (2**idx_w entries) is representable.
    function automatic int unsigned cnt_width(int unsigned idx_w);
        return idx_w + 1;
    endfunction

endpackage

// File: rtl/tcam_prio_enc.sv
// Lowest-index priority encoder.
//   req   : request vector, bit 0 has highest priority
//   index : index of the lowest set bit (0 when none set)
//   any   : at least one bit set
//   multi : two or more bits set
module tcam_prio_enc #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IDX_W = 5
) (
    input  logic [WIDTH-1:0] req,
    output logic [IDX_W-1:0] index,
    output logic             any,
    output logic             multi
);

    always_comb begin
        index = '0;
        // Scan downwards so the lowest set bit is the last one assigned.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = IDX_W'(i);
            end
        end
    end

    assign any   = |req;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = |(req & (req - WIDTH'(1)));

endmodule

// File: rtl/tcam_array.sv
// Parametrised ternary CAM with per-entry valid bits and care masks.
//   read/read_index                 -> read_value, read_mask, read_valid
//   write/write_index/write_data/write_mask : indexed store, sets valid
//   insert (uses write_data/write_mask) -> insert_index, insert_done, insert_fail
//   invalidate/invalidate_index     : clears valid only, contents retained
//   search/search_data              -> search_index, search_valid, search_multi
//   count/full/empty                : occupancy
// All results are registered and appear one cycle after the request.
module tcam_array
    import tcam_pkg::*;
#(
    parameter int unsigned IDX_W  = DEF_IDX_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read,
    input  logic [IDX_W-1:0]  read_index,
    input  logic              write,
    input  logic [IDX_W-1:0]  write_index,
    input  logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] write_mask,
    input  logic              insert,
    input  logic              invalidate,
    input  logic [IDX_W-1:0]  invalidate_index,
    input  logic              search,
    input  logic [DATA_W-1:0] search_data,
    output logic [DATA_W-1:0] read_value,
    output logic [DATA_W-1:0] read_mask,
    output logic              read_valid,
    output logic [IDX_W-1:0]  search_index,
    output logic              search_valid,
    output logic              search_multi,
    output logic [IDX_W-1:0]  insert_index,
    output logic              insert_done,
    output logic              insert_fail,
    output logic [IDX_W:0]    count,
    output logic              full,
    output logic              empty
);

    localparam int unsigned      DEPTH = 2 ** IDX_W;
    localparam int unsigned      CNT_W = cnt_width(IDX_W);
    localparam logic [IDX_W-1:0] MISS  = IDX_W'(MISS_INDEX_ALL);

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] mask_q [DEPTH];
    logic [CNT_W-1:0]  count_q, count_d;

    logic [DEPTH-1:0]  match;
    logic [IDX_W-1:0]  hit_index, free_index;
    logic              hit_any, hit_multi, free_any, unused_free_multi;
    logic              insert_ok;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = valid_q[i] && (((data_q[i] ^ search_data) & mask_q[i]) == '0);
        end
    end

    tcam_prio_enc #(
        .WIDTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_match_enc (
        .req   (match),
        .index (hit_index),
        .any   (hit_any),
        .multi (hit_multi)
    );

    // Free-slot search works on the pre-edge valid vector, so a slot being
    // invalidated this cycle is not visible to a concurrent insert.
    tcam_prio_enc #(
        .WIDTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_free_enc (
        .req   (~valid_q),
        .index (free_index),
        .any   (free_any),
        .multi (unused_free_multi)
    );

    assign insert_ok = insert && !write && free_any;

    // Invalidate is applied first so a same-index write overrides it.
    always_comb begin
        valid_d = valid_q;
        if (invalidate) valid_d[invalidate_index] = 1'b0;
        if (write)      valid_d[write_index]      = 1'b1;
        if (insert_ok)  valid_d[free_index]       = 1'b1;
    end

    always_comb begin
        count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_d = count_d + CNT_W'(valid_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= '0;
            count_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                mask_q[i] <= '0;
            end
            read_value   <= '0;
            read_mask    <= '0;
            read_valid   <= 1'b0;
            search_index <= MISS;
            search_valid <= 1'b0;
            search_multi <= 1'b0;
            insert_index <= '0;
            insert_done  <= 1'b0;
            insert_fail  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;

            if (write) begin
                data_q[write_index] <= write_data;
                mask_q[write_index] <= write_mask;
            end
            if (insert_ok) begin
                data_q[free_index] <= write_data;
                mask_q[free_index] <= write_mask;
            end

            read_valid <= 1'b0;
            if (read) begin
                read_value <= data_q[read_index];
                read_mask  <= mask_q[read_index];
                read_valid <= valid_q[read_index];
            end

            search_valid <= 1'b0;
            search_multi <= 1'b0;
            if (search) begin
                search_index <= hit_any ? hit_index : MISS;
                search_valid <= hit_any;
                search_multi <= hit_multi;
            end

            insert_done <= insert_ok;
            insert_fail <= insert && !insert_ok;
            if (insert_ok) insert_index <= free_index;
        end
    end

    assign count = count_q;
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: tb/tb_tcam_array.sv
module tb_tcam_array;

    localparam int IDX_W  = 5;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              read, write, insert, invalidate, search;
    logic [IDX_W-1:0]  read_index, write_index, invalidate_index;
    logic [DATA_W-1:0] write_data, write_mask, search_data;
    logic [DATA_W-1:0] read_value, read_mask;
    logic              read_valid, search_valid, search_multi, insert_done, insert_fail;
    logic [IDX_W-1:0]  search_index, insert_index;
    logic [IDX_W:0]    count;
    logic              full, empty;

    int checks = 0;
    int errors = 0;

    // Reference model state and expected registered outputs.
    logic              m_valid [DEPTH];
    logic [DATA_W-1:0] m_data  [DEPTH];
    logic [DATA_W-1:0] m_mask  [DEPTH];
    logic [DATA_W-1:0] e_rv, e_rm;
    logic              e_rvld, e_sv, e_sm, e_idone, e_ifail;
    logic [IDX_W-1:0]  e_sidx, e_iidx;

    always #5 clk = ~clk;

    tcam_array #(
        .IDX_W  (IDX_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .read             (read),
        .read_index       (read_index),
        .write            (write),
        .write_index      (write_index),
        .write_data       (write_data),
        .write_mask       (write_mask),
        .insert           (insert),
        .invalidate       (invalidate),
        .invalidate_index (invalidate_index),
        .search           (search),
        .search_data      (search_data),
        .read_value       (read_value),
        .read_mask        (read_mask),
        .read_valid       (read_valid),
        .search_index     (search_index),
        .search_valid     (search_valid),
        .search_multi     (search_multi),
        .insert_index     (insert_index),
        .insert_done      (insert_done),
        .insert_fail      (insert_fail),
        .count            (count),
        .full             (full),
        .empty            (empty)
    );

    task automatic idle();
        read = 0; write = 0; insert = 0; invalidate = 0; search = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 0; m_data[i] = '0; m_mask[i] = '0;
        end
        e_rv = '0; e_rm = '0; e_rvld = 0; e_sidx = '1; e_sv = 0; e_sm = 0;
        e_iidx = '0; e_idone = 0; e_ifail = 0;
    endtask

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) if (m_valid[i]) n++;
        return n;
    endfunction

    // Applies one clock of requests to the model using the pre-edge state.
    task automatic model_step();
        int first = -1;
        int hits  = 0;
        int free  = -1;
        bit ok;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_valid[i] && (((m_data[i] ^ search_data) & m_mask[i]) == 0)) begin
                if (first < 0) first = i;
                hits++;
            end
            if (!m_valid[i] && free < 0) free = i;
        end
        if (read) begin
            e_rv = m_data[read_index]; e_rm = m_mask[read_index]; e_rvld = m_valid[read_index];
        end else begin
            e_rvld = 0;
        end
        if (search) begin
            e_sidx = (first < 0) ? 5'd31 : 5'(first);
            e_sv = (hits > 0); e_sm = (hits > 1);
        end else begin
            e_sv = 0; e_sm = 0;
        end
        ok = insert && !write && (free >= 0);
        e_idone = ok;
        e_ifail = insert && !ok;
        if (ok) e_iidx = 5'(free);
        if (invalidate) m_valid[invalidate_index] = 0;
        if (write) begin
            m_valid[write_index] = 1; m_data[write_index] = write_data;
            m_mask[write_index] = write_mask;
        end
        if (ok) begin
            m_valid[free] = 1; m_data[free] = write_data; m_mask[free] = write_mask;
        end
    endtask

    // Inputs were set on the falling edge; sample 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 1;
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        rst = 0;
        model_reset();
        checks++;
        if (search_index !== 5'd31 || search_valid !== 0 || search_multi !== 0) begin
            errors++;
            $display("FAIL reset_search got idx=%0d v=%0b m=%0b exp idx=31 v=0 m=0",
                     search_index, search_valid, search_multi);
        end
        checks++;
        if (count !== 6'd0 || empty !== 1 || full !== 0) begin
            errors++;
            $display("FAIL reset_count got cnt=%0d e=%0b f=%0b exp 0 1 0", count, empty, full);
        end
        checks++;
        if (read_value !== 0 || read_mask !== 0 || read_valid !== 0 || insert_index !== 0
            || insert_done !== 0 || insert_fail !== 0) begin
            errors++;
            $display("FAIL reset_misc got rv=%0h rm=%0h rvld=%0b ii=%0d id=%0b if=%0b exp zeros",
                     read_value, read_mask, read_valid, insert_index, insert_done, insert_fail);
        end
        @(negedge clk); idle(); search = 1; search_data = 0;
        cyc();
        checks++;
        if (search_index !== 5'd31 || search_valid !== 0 || count !== 0 || empty !== 1) begin
            errors++;
            $display("FAIL empty_search got idx=%0d v=%0b cnt=%0d e=%0b exp 31 0 0 1",
                     search_index, search_valid, count, empty);
        end
    endtask

    task automatic test_write_search();
        @(negedge clk); idle();
        write = 1; write_index = 9; write_data = 7; write_mask = '1;
        cyc();
        @(negedge clk); idle();
        search = 1; search_data = 7; read = 1; read_index = 9;
        cyc();
        checks++;
        if (search_index !== 5'd9 || search_valid !== 1) begin
            errors++;
            $display("FAIL write_search got idx=%0d v=%0b exp 9 1", search_index, search_valid);
        end
        checks++;
        if (read_value !== 7 || read_valid !== 1 || read_mask !== 32'hFFFF_FFFF || count !== 1)
        begin
            errors++;
            $display("FAIL write_read got rv=%0h rm=%0h rvld=%0b cnt=%0d exp 7 ffffffff 1 1",
                     read_value, read_mask, read_valid, count);
        end
    endtask

    task automatic test_mask_multi();
        @(negedge clk); idle();
        write = 1; write_index = 3; write_data = 32'h10; write_mask = 32'hFFFF_FFF0;
        cyc();
        @(negedge clk); idle();
        write = 1; write_index = 5; write_data = 32'h15; write_mask = '1;
        cyc();
        @(negedge clk); idle();
        search = 1; search_data = 32'h15;
        cyc();
        checks++;
        if (search_index !== 5'd3 || search_valid !== 1 || search_multi !== 1) begin
            errors++;
            $display("FAIL mask_multi got idx=%0d v=%0b m=%0b exp 3 1 1",
                     search_index, search_valid, search_multi);
        end
        @(negedge clk); idle();
        invalidate = 1; invalidate_index = 3;
        cyc();
        checks++;
        if (search_valid !== 0 || search_multi !== 0 || search_index !== 5'd3) begin
            errors++;
            $display("FAIL search_idle got idx=%0d v=%0b m=%0b exp 3 0 0",
                     search_index, search_valid, search_multi);
        end
        @(negedge clk); idle();
        search = 1; search_data = 32'h15;
        cyc();
        checks++;
        if (search_index !== 5'd5 || search_valid !== 1 || search_multi !== 0) begin
            errors++;
            $display("FAIL after_invalidate got idx=%0d v=%0b m=%0b exp 5 1 0",
                     search_index, search_valid, search_multi);
        end
    endtask

    task automatic test_insert_fill();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk); idle();
            insert = 1; write_data = 32'(i * 3); write_mask = '1;
            cyc();
            checks++;
            if (insert_index !== 5'(i) || insert_done !== 1 || insert_fail !== 0) begin
                errors++;
                $display("FAIL insert_%0d got idx=%0d d=%0b f=%0b exp %0d 1 0",
                         i, insert_index, insert_done, insert_fail, i);
            end
        end
        checks++;
        if (full !== 1 || count !== 6'd32 || empty !== 0) begin
            errors++;
            $display("FAIL fill_full got f=%0b cnt=%0d exp 1 32", full, count);
        end
        @(negedge clk); idle(); insert = 1;
        cyc();
        checks++;
        if (insert_fail !== 1 || insert_done !== 0 || count !== 6'd32) begin
            errors++;
            $display("FAIL insert_full got f=%0b d=%0b cnt=%0d exp 1 0 32",
                     insert_fail, insert_done, count);
        end
        @(negedge clk); idle(); insert = 1; invalidate = 1; invalidate_index = 4;
        cyc();
        checks++;
        if (insert_fail !== 1 || insert_done !== 0 || count !== 6'd31) begin
            errors++;
            $display("FAIL insert_inval got f=%0b d=%0b cnt=%0d exp 1 0 31",
                     insert_fail, insert_done, count);
        end
        @(negedge clk); idle(); insert = 1; write_data = 32'hABCD;
        cyc();
        checks++;
        if (insert_index !== 5'd4 || insert_done !== 1 || count !== 6'd32) begin
            errors++;
            $display("FAIL reinsert got idx=%0d d=%0b cnt=%0d exp 4 1 32",
                     insert_index, insert_done, count);
        end
        @(negedge clk); idle(); insert = 1; write = 1; write_index = 0;
        do_reset_skip: begin end
        cyc();
        checks++;
        if (insert_fail !== 1 || insert_done !== 0) begin
            errors++;
            $display("FAIL insert_with_write got f=%0b d=%0b exp 1 0", insert_fail, insert_done);
        end
    endtask

    task automatic test_write_inval();
        do_reset();
        @(negedge clk); idle();
        write = 1; write_index = 2; write_data = 32'h22; write_mask = '1;
        cyc();
        @(negedge clk); idle();
        write = 1; write_index = 6; write_data = 32'h66; invalidate = 1; invalidate_index = 6;
        cyc();
        checks++;
        if (count !== 6'd2) begin
            errors++;
            $display("FAIL write_inval_same got cnt=%0d exp 2", count);
        end
        @(negedge clk); idle();
        write = 1; write_index = 12; write_data = 32'hC; invalidate = 1; invalidate_index = 2;
        read = 1; read_index = 6;
        cyc();
        checks++;
        if (count !== 6'd2 || read_valid !== 1 || read_value !== 32'h66) begin
            errors++;
            $display("FAIL write_inval_diff got cnt=%0d rvld=%0b rv=%0h exp 2 1 66",
                     count, read_valid, read_value);
        end
        @(negedge clk); idle(); read = 1; read_index = 2;
        cyc();
        checks++;
        if (read_valid !== 0 || read_value !== 32'h22) begin
            errors++;
            $display("FAIL read_invalid got rvld=%0b rv=%0h exp 0 22", read_valid, read_value);
        end
        @(negedge clk); idle();
        cyc();
        checks++;
        if (read_valid !== 0 || read_value !== 32'h22) begin
            errors++;
            $display("FAIL read_hold got rvld=%0b rv=%0h exp 0 22", read_valid, read_value);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk); idle();
            read             = ($urandom_range(0, 1) == 1);
            read_index       = 5'($urandom);
            write            = ($urandom_range(0, 3) == 0);
            write_index      = 5'($urandom);
            insert           = ($urandom_range(0, 9) < 3);
            invalidate       = ($urandom_range(0, 3) == 0);
            invalidate_index = 5'($urandom);
            write_data       = 32'($urandom_range(0, 15));
            write_mask       = {28'hFFF_FFFF, 4'($urandom)};
            search           = ($urandom_range(0, 9) < 7);
            search_data      = 32'($urandom_range(0, 15));
            cyc();
            checks++;
            if ({read_value, read_mask, read_valid} !== {e_rv, e_rm, e_rvld}) begin
                errors++;
                $display("FAIL rand_read[%0d] got %h/%h/%b exp %h/%h/%b", n,
                         read_value, read_mask, read_valid, e_rv, e_rm, e_rvld);
            end
            checks++;
            if ({search_index, search_valid, search_multi} !== {e_sidx, e_sv, e_sm}) begin
                errors++;
                $display("FAIL rand_search[%0d] got %0d/%b/%b exp %0d/%b/%b", n,
                         search_index, search_valid, search_multi, e_sidx, e_sv, e_sm);
            end
            checks++;
            if ({insert_index, insert_done, insert_fail} !== {e_iidx, e_idone, e_ifail}) begin
                errors++;
                $display("FAIL rand_insert[%0d] got %0d/%b/%b exp %0d/%b/%b", n,
                         insert_index, insert_done, insert_fail, e_iidx, e_idone, e_ifail);
            end
            checks++;
            if (count !== 6'(model_count()) || full !== (model_count() == DEPTH)
                || empty !== (model_count() == 0)) begin
                errors++;
                $display("FAIL rand_count[%0d] got %0d/%b/%b exp %0d", n,
                         count, full, empty, model_count());
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); idle();
        search = 1; search_data = 0; insert = 1; write_data = 0; write_mask = 0;
        #2 rst = 1;
        #1;
        checks++;
        if (count !== 0 || empty !== 1 || full !== 0 || search_index !== 5'd31
            || search_valid !== 0 || insert_done !== 0 || insert_fail !== 0
            || insert_index !== 0 || read_valid !== 0 || read_value !== 0) begin
            errors++;
            $display("FAIL async_reset got cnt=%0d si=%0d sv=%0b id=%0b if=%0b ii=%0d rv=%0h",
                     count, search_index, search_valid, insert_done, insert_fail,
                     insert_index, read_value);
        end
        @(posedge clk); #1;
        checks++;
        if (insert_done !== 0 || insert_fail !== 0 || search_valid !== 0 || count !== 0) begin
            errors++;
            $display("FAIL reset_drop got id=%0b if=%0b sv=%0b cnt=%0d exp 0 0 0 0",
                     insert_done, insert_fail, search_valid, count);
        end
        @(negedge clk);
        rst = 0; idle(); model_reset();
        @(negedge clk); idle(); search = 1; search_data = 0;
        cyc();
        checks++;
        if (search_valid !== 0 || search_index !== 5'd31 || count !== 0) begin
            errors++;
            $display("FAIL post_reset_search got v=%0b idx=%0d cnt=%0d exp 0 31 0",
                     search_valid, search_index, count);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        idle();
        read_index = 0; write_index = 0; invalidate_index = 0;
        write_data = 0; write_mask = 0; search_data = 0;
        model_reset();
        test_reset();
        test_write_search();
        test_mask_multi();
        test_insert_fill();
        test_write_inval();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tcam_array.md
# tcam_array

Parametrised ternary CAM: the next generation of the team's 32-entry binary CAM, with configurable depth and width, per-entry valid bits, per-entry don't-care masks, auto-insert into the lowest free slot, invalidate, multi-match detection and occupancy tracking. It sits beside the lookup pipeline as a single-clock storage/search block. All results are registered and appear one cycle after the request.

## Interface
- IDX_W, 5, index width; DEPTH = 2**IDX_W entries
- DATA_W, 32, key/entry width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- read  in  1  read request
- read_index  in  IDX_W  entry to read
- write  in  1  indexed write request
- write_index  in  IDX_W  entry to write
- write_data  in  DATA_W  data for write/insert
- write_mask  in  DATA_W  care mask for write/insert; 1 = compare bit, 0 = don't care
- insert  in  1  write write_data/write_mask into the lowest-index invalid entry
- invalidate  in  1  clear the valid bit of invalidate_index
- invalidate_index  in  IDX_W  entry to invalidate
- search  in  1  search request
- search_data  in  DATA_W  search key
- read_value  out  DATA_W  stored data
- read_mask  out  DATA_W  stored mask
- read_valid  out  1  read done and entry valid
- search_index  out  IDX_W  lowest matching index; all-ones on a miss
- search_valid  out  1  at least one match
- search_multi  out  1  two or more matches
- insert_index  out  IDX_W  slot used by the insert
- insert_done  out  1  insert succeeded (one-cycle pulse)
- insert_fail  out  1  insert rejected (one-cycle pulse)
- count  out  IDX_W+1  number of valid entries
- full, empty  out  1 each  count == DEPTH / count == 0

## Operation
- Entry i matches when valid[i] and ((data[i] ^ search_data) & mask[i]) == 0.
- All operations in a cycle see the array state from before that cycle's edge (read-before-write).
- Write: stores data and mask, sets valid. count increments only if the entry was invalid.
- Insert: picks the lowest-index invalid entry. It is rejected (insert_fail) when the array is full or when write is also asserted. Nothing is stored on a rejected insert.
- Invalidate: clears the valid bit only; data and mask are retained. count decrements only if the entry was valid.
- Write and invalidate to the same index in one cycle: the write wins and the entry stays valid.
- Write and invalidate to different indices: both take effect, and count changes by the net amount.
- Insert and invalidate in the same cycle: the insert does not see the slot being freed, so a full array still rejects the insert.
- Invalidating an entry that is already invalid has no effect.
- Read of an invalid entry: read_value and read_mask return the stored contents; read_valid = 0.
- No request on a port: that port's outputs hold their last value. Exceptions: the insert_done/insert_fail pulses clear, and read_valid, search_valid and search_multi drop to 0.

## Timing
- Request sampled at edge N; result valid after edge N, for one cycle.
- Back-to-back requests every cycle are supported, with no stalls and no handshake.
- A search issued the cycle after a write sees the written entry.
- Reset values: all valid bits 0, data and mask 0, read_value 0, read_mask 0, read_valid 0, search_index all-ones, search_valid 0, search_multi 0, insert_index 0, insert_done 0, insert_fail 0, count 0, empty 1, full 0.
- Reset asserted mid-operation clears everything immediately. Any pending result is dropped.

## Structure
- Package tcam_pkg holds the shared constants: the miss index (all-ones) and the count width (IDX_W+1).
- Sub-module tcam_prio_enc is a parametrised lowest-index priority encoder with an any-hit output and a multi-hit output. It is instantiated twice:
  - on the match vector, for search;
  - on the inverted valid vector, for the free slot.

## Test plan
- Reset, then search 0 -> search_index 31, search_valid 0, count 0, empty 1.
- Write 7 with mask all-ones at index 9; next cycle search 7 and read 9 -> search_index 9, search_valid 1, read_value 7, read_valid 1, count 1.
- Write 0x10 with mask 0xFFFFFFF0 at index 3 and 0x15 with mask all-ones at index 5; search 0x15 -> search_index 3, search_multi 1. Then invalidate 3 and search again -> search_index 5, search_multi 0.
- Issue 32 inserts -> insert_index 0..31, then full 1. A 33rd insert -> insert_fail 1, count stays 32. Insert plus invalidate 4 in the same cycle -> insert_fail; the next insert -> insert_index 4.
- Write index 6 and invalidate index 6 in the same cycle -> entry 6 valid, count +1. Write 12 and invalidate valid entry 2 in the same cycle -> count unchanged.
- Assert rst while a search and an insert are in flight -> no result pulses; all outputs at reset values; count 0.
